// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and defaults for the memory arbiter slice.
//   state_t : arbiter FSM encoding (IDLE, CMD, RDWAIT)
//   DEF_AW  : default memory address width
//   DEF_DW  : default memory data width
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CMD    = 2'd1,
        RDWAIT = 2'd2
    } state_t;

    localparam int DEF_AW = 2;
    localparam int DEF_DW = 8;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin search.
//   req     : per-requester request bits
//   ptr     : index with highest priority this cycle
//   winner  : first set req bit at or above ptr, wrapping modulo NREQ
//   any_req : at least one req bit is set (winner is valid)
module rr_pick #(
    parameter int NREQ = 2,
    parameter int PW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [PW-1:0]   winner,
    output logic            any_req
);

    int idx_s;

    // Walk from ptr upward; the first requester found wins.
    always_comb begin
        winner  = {PW{1'b0}};
        any_req = 1'b0;
        idx_s   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx_s = (int'(ptr) + k) % NREQ;
            if (!any_req && req[idx_s[PW-1:0]]) begin
                winner  = idx_s[PW-1:0];
                any_req = 1'b1;
            end else begin
                winner  = winner;
                any_req = any_req;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one single-port memory between
// NREQ requesters. One command is in flight at a time.
//   clk, reset            : clock (rising edge), async active-high reset
//   req/we/addr/wdata     : per-requester command inputs (packed per requester)
//   gnt                   : one-hot pulse, command accepted
//   rvalid/rdata          : one-hot read-return pulse, broadcast read data
//   mem_wr_en/mem_rd_en   : memory command strobes (never both high)
//   mem_address/mem_w_data: memory command fields
//   mem_r_data            : memory read data, valid the cycle after rd_en
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = DEF_AW,
    parameter int DW   = DEF_DW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NREQ-1:0]  req,
    input  logic [NREQ-1:0]  we,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]  gnt,
    output logic [NREQ-1:0]  rvalid,
    output logic [DW-1:0]    rdata,
    output logic             mem_wr_en,
    output logic             mem_rd_en,
    output logic [AW-1:0]    mem_address,
    output logic [DW-1:0]    mem_w_data,
    input  logic [DW-1:0]    mem_r_data
);

    localparam int PW = (NREQ > 2) ? 2 : 1;

    state_t          state_r;
    logic [PW-1:0]   rr_ptr_r;
    logic [PW-1:0]   owner_r;
    logic [PW-1:0]   win_s;
    logic            any_s;
    logic [PW-1:0]   next_ptr_s;
    logic            cmd_we_s;
    logic [AW-1:0]   cmd_addr_s;
    logic [DW-1:0]   cmd_wdata_s;

    function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] idx);
        logic [NREQ-1:0] v;
        v      = {NREQ{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
        .req     (req),
        .ptr     (rr_ptr_r),
        .winner  (win_s),
        .any_req (any_s)
    );

    // Mux the winning requester's command fields and compute the pointer after it.
    always_comb begin
        cmd_we_s    = 1'b0;
        cmd_addr_s  = {AW{1'b0}};
        cmd_wdata_s = {DW{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            if (win_s == PW'(i)) begin
                cmd_we_s    = we[i];
                cmd_addr_s  = addr[i*AW +: AW];
                cmd_wdata_s = wdata[i*DW +: DW];
            end else begin
                cmd_we_s    = cmd_we_s;
                cmd_addr_s  = cmd_addr_s;
                cmd_wdata_s = cmd_wdata_s;
            end
        end
        if (win_s == PW'(NREQ - 1)) begin
            next_ptr_s = {PW{1'b0}};
        end else begin
            next_ptr_s = win_s + PW'(1'b1);
        end
    end

    // Arbiter FSM with registered command, grant and read-return outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            rr_ptr_r    <= {PW{1'b0}};
            owner_r     <= {PW{1'b0}};
            gnt         <= {NREQ{1'b0}};
            rvalid      <= {NREQ{1'b0}};
            rdata       <= {DW{1'b0}};
            mem_wr_en   <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_address <= {AW{1'b0}};
            mem_w_data  <= {DW{1'b0}};
        end else begin
            // Pulses default low; address and write data hold.
            gnt       <= {NREQ{1'b0}};
            rvalid    <= {NREQ{1'b0}};
            mem_wr_en <= 1'b0;
            mem_rd_en <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (any_s) begin
                        gnt         <= onehot(win_s);
                        mem_address <= cmd_addr_s;
                        mem_w_data  <= cmd_wdata_s;
                        mem_wr_en   <= cmd_we_s;
                        mem_rd_en   <= ~cmd_we_s;
                        rr_ptr_r    <= next_ptr_s;
                        owner_r     <= win_s;
                        state_r     <= CMD;
                    end else begin
                        state_r     <= IDLE;
                    end
                end
                CMD: begin
                    // mem_wr_en still reflects the command being sampled now.
                    if (mem_wr_en) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= RDWAIT;
                    end
                end
                RDWAIT: begin
                    rdata   <= mem_r_data;
                    rvalid  <= onehot(owner_r);
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    logic       clk;
    logic       reset;
    logic [1:0] req;
    logic [1:0] we;
    logic [3:0] addr;
    logic [15:0] wdata;
    logic [1:0] gnt;
    logic [1:0] rvalid;
    logic [7:0] rdata;
    logic       mem_wr_en;
    logic       mem_rd_en;
    logic [1:0] mem_address;
    logic [7:0] mem_w_data;
    logic [7:0] mem_r_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] mem_model [4];

    mem_arbiter #(.NREQ(2), .AW(2), .DW(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .we          (we),
        .addr        (addr),
        .wdata       (wdata),
        .gnt         (gnt),
        .rvalid      (rvalid),
        .rdata       (rdata),
        .mem_wr_en   (mem_wr_en),
        .mem_rd_en   (mem_rd_en),
        .mem_address (mem_address),
        .mem_w_data  (mem_w_data),
        .mem_r_data  (mem_r_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port 4x8 memory: r_data updates on the edge that samples rd_en.
    always @(posedge clk) begin
        if (mem_wr_en) mem_model[mem_address] <= mem_w_data;
        if (mem_rd_en) mem_r_data <= mem_model[mem_address];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Strobes must never be high together.
    always @(negedge clk) begin
        if (!reset && mem_wr_en && mem_rd_en)
            check("rw_exclusive", {30'd0, mem_wr_en, mem_rd_en}, 32'd0);
    end

    // Window monitor for the withdrawal test.
    bit   win_on = 0;
    int   gnt1_cnt = 0;
    int   wr_cnt = 0;
    always @(negedge clk) begin
        if (win_on) begin
            if (gnt[1]) gnt1_cnt++;
            if (mem_wr_en || mem_rd_en) wr_cnt++;
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // One command from requester r, checking gnt timing, memory port and return.
    task automatic issue(input int r, input logic w, input logic [1:0] a,
                         input logic [7:0] d, input logic [7:0] exp_d);
        int start;
        bit got;
        @(posedge clk); #1;
        req[r] = 1'b1; we[r] = w; addr[r*2 +: 2] = a; wdata[r*8 +: 8] = d;
        start = cyc;
        got = 0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            if (gnt[r]) got = 1;
        end
        check("gnt_seen", {31'd0, got}, 32'd1);
        check("gnt_latency", cyc - start, 32'd1);
        check("gnt_onehot", {30'd0, gnt}, 32'd1 << r);
        check("mem_address", {30'd0, mem_address}, {30'd0, a});
        check("mem_wr_en", {31'd0, mem_wr_en}, {31'd0, w});
        check("mem_rd_en", {31'd0, mem_rd_en}, {31'd0, ~w});
        if (w) check("mem_w_data", {24'd0, mem_w_data}, {24'd0, d});
        @(posedge clk); #1;
        req[r] = 1'b0;
        if (w) begin
            check("mem_commit", {24'd0, mem_model[a]}, {24'd0, d});
        end else begin
            got = 0;
            for (int n = 0; n < 10 && !got; n++) begin
                @(negedge clk);
                if (rvalid != 2'b00) got = 1;
            end
            check("rvalid_seen", {31'd0, got}, 32'd1);
            check("rvalid_latency", cyc - start, 32'd3);
            check("rvalid_onehot", {30'd0, rvalid}, 32'd1 << r);
            check("rdata", {24'd0, rdata}, {24'd0, exp_d});
        end
    endtask

    typedef struct {
        int         r;
        logic       w;
        logic [1:0] a;
        logic [7:0] d;
        logic [7:0] exp_d;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int start, g0, g1, cnt, bad;
        int order [8];
        int gcyc  [8];
        bit got;

        for (int i = 0; i < 4; i++) mem_model[i] = 8'h00;
        mem_r_data = 8'h00;
        req = 2'b00; we = 2'b00; addr = 4'h0; wdata = 16'h0000;
        reset = 1'b1;

        vecs[0] = '{0, 1'b1, 2'd2, 8'hA5, 8'h00};
        vecs[1] = '{0, 1'b0, 2'd2, 8'h00, 8'hA5};
        vecs[2] = '{1, 1'b1, 2'd3, 8'h3C, 8'h00};
        vecs[3] = '{1, 1'b0, 2'd3, 8'h00, 8'h3C};
        vecs[4] = '{0, 1'b1, 2'd0, 8'hFF, 8'h00};
        vecs[5] = '{1, 1'b0, 2'd0, 8'h00, 8'hFF};
        vecs[6] = '{0, 1'b0, 2'd2, 8'h00, 8'hA5};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt", {30'd0, gnt}, 32'd0);
        check("rst_rvalid", {30'd0, rvalid}, 32'd0);
        check("rst_rdata", {24'd0, rdata}, 32'd0);
        check("rst_strobes", {30'd0, mem_wr_en, mem_rd_en}, 32'd0);
        check("rst_addr_data", {22'd0, mem_address, mem_w_data}, 32'd0);
        reset = 1'b0;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (gnt != 2'b00 || rvalid != 2'b00) bad++;
        end
        check("idle_quiet", bad, 32'd0);

        // Directed single-requester table.
        for (int i = 0; i < 7; i++)
            issue(vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp_d);

        // Contention from reset pointer: r0 first, r1 two cycles later.
        do_reset();
        @(posedge clk); #1;
        req = 2'b11; we = 2'b11; addr = {2'd1, 2'd0}; wdata = {8'h22, 8'h11};
        start = cyc; g0 = -1; g1 = -1;
        for (int n = 0; n < 20 && (g0 < 0 || g1 < 0); n++) begin
            @(negedge clk);
            if (gnt[0]) g0 = cyc - start;
            if (gnt[1]) g1 = cyc - start;
            @(posedge clk); #1;
            if (g0 >= 0) req[0] = 1'b0;
            if (g1 >= 0) req[1] = 1'b0;
        end
        req = 2'b00;
        check("cont_gnt0_cycle", g0, 32'd1);
        check("cont_gnt1_cycle", g1, 32'd3);
        issue(0, 1'b0, 2'd0, 8'h00, 8'h11);
        issue(1, 1'b0, 2'd1, 8'h00, 8'h22);

        // Fairness with both requesters writing continuously.
        do_reset();
        @(posedge clk); #1;
        req = 2'b11; we = 2'b11; addr = {2'd1, 2'd0}; wdata = {8'h22, 8'h11};
        cnt = 0;
        for (int n = 0; n < 40 && cnt < 8; n++) begin
            @(negedge clk);
            if (gnt != 2'b00) begin
                order[cnt] = gnt[1] ? 1 : 0;
                gcyc[cnt]  = cyc;
                cnt++;
            end
        end
        @(posedge clk); #1;
        req = 2'b00;
        check("fair_count", cnt, 32'd8);
        for (int i = 0; i < cnt; i++) begin
            check("fair_order", order[i], i % 2);
            if (i > 0) check("fair_gap", gcyc[i] - gcyc[i-1], 32'd2);
        end

        // Withdrawal: r1 requests while r0 is being served, then drops.
        repeat (2) @(posedge clk);
        #1;
        win_on = 1; gnt1_cnt = 0; wr_cnt = 0;
        req[0] = 1'b1; we[0] = 1'b1; addr[1:0] = 2'd3; wdata[7:0] = 8'h77;
        @(posedge clk); #1;
        check("wd_gnt0", {30'd0, gnt}, 32'd1);
        req[1] = 1'b1; we[1] = 1'b1; addr[3:2] = 2'd2; wdata[15:8] = 8'hEE;
        @(posedge clk); #1;
        req = 2'b00;
        repeat (10) @(posedge clk);
        #1;
        win_on = 0;
        check("wd_no_gnt1", gnt1_cnt, 32'd0);
        check("wd_one_access", wr_cnt, 32'd1);
        check("wd_mem2_kept", {24'd0, mem_model[2]}, 32'hA5);
        check("wd_mem3_written", {24'd0, mem_model[3]}, 32'h77);

        // Reset in RDWAIT: r0 read moves rr_ptr to 1, reset must restore 0.
        @(posedge clk); #1;
        req[0] = 1'b1; we[0] = 1'b0; addr[1:0] = 2'd0;
        @(posedge clk); #1;
        check("mr_gnt0", {30'd0, gnt}, 32'd1);
        @(posedge clk); #1;
        req = 2'b00;
        #2;
        reset = 1'b1;
        #1;
        check("mr_gnt", {30'd0, gnt}, 32'd0);
        check("mr_rvalid", {30'd0, rvalid}, 32'd0);
        check("mr_rdata", {24'd0, rdata}, 32'd0);
        check("mr_strobes", {30'd0, mem_wr_en, mem_rd_en}, 32'd0);
        check("mr_addr", {30'd0, mem_address}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (rvalid != 2'b00 || gnt != 2'b00) bad++;
        end
        check("mr_no_pulse", bad, 32'd0);
        @(posedge clk); #1;
        req = 2'b11; we = 2'b00; addr = {2'd1, 2'd0};
        got = 0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            if (gnt != 2'b00) got = 1;
        end
        check("mr_first_gnt", {30'd0, gnt}, 32'd1);
        @(posedge clk); #1;
        req = 2'b00;
        got = 0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            if (rvalid != 2'b00) got = 1;
        end
        check("mr_rvalid_after", {30'd0, rvalid}, 32'd1);
        check("mr_rdata_after", {24'd0, rdata}, 32'h11);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
